// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C write master.
// FSM encoding, quarter-period indices, R/W bit and default slave address.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADDR,
      ACK1,
      DATA,
      ACK2,
      STOP
   } state_t;

   localparam logic WRITE_BIT = 1'b0;

   localparam logic [1:0] QP0 = 2'd0;
   localparam logic [1:0] QP1 = 2'd1;
   localparam logic [1:0] QP2 = 2'd2;
   localparam logic [1:0] QP3 = 2'd3;

   localparam logic [6:0] DEF_SLAVE_ADDR = 7'b1101111;

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: host request/status bundle for the I2C master.
// master = host logic (req/addr/data out), slave = controller (busy/done/nack out).
interface i2c_master_ctrl_if;

   logic       req;
   logic [6:0] addr;
   logic [7:0] data;
   logic       busy;
   logic       done;
   logic       nack;

   modport master (
      output req, addr, data,
      input  busy, done, nack
   );

   modport slave (
      input  req, addr, data,
      output busy, done, nack
   );

endinterface

// File: rtl/i2c_master_ctrl_qp_tick.sv
// i2c_qp_tick: SCL quarter-period divider, counts 0..CLK_DIV-1 while en.
// Ports: clk, rst (sync, high), en (count enable), tick (high on wrap cycle).
module i2c_qp_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: write-only I2C master, START/addr+W/ACK/data/ACK/STOP.
// Ports: clk, rst (sync, high), host (req/addr/data in, busy/done/nack out), sda/scl open drain.
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   i2c_master_ctrl_if.slave    host,
   inout  wire                 sda,
   output wire                 scl
);

   state_t     state;
   logic [1:0] qp;
   logic [2:0] bitc;
   logic [7:0] shreg;
   logic [7:0] data_q;
   logic       nack_f;
   logic       sda_lo;
   logic       scl_lo;
   logic       busy_r;
   logic       done_r;
   logic       nack_r;
   logic       tick;
   logic       sda_in;

   i2c_qp_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state != IDLE),
      .tick (tick)
   );

   assign sda_in = sda;

   // Outputs registered so each bus change lands on the edge opening a QP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         qp     <= QP0;
         bitc   <= '0;
         shreg  <= '0;
         data_q <= '0;
         nack_f <= 1'b0;
         sda_lo <= 1'b0;
         scl_lo <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         nack_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         nack_r <= 1'b0;
         if (state == IDLE) begin
            if (host.req) begin
               state  <= START;
               qp     <= QP0;
               bitc   <= '0;
               shreg  <= {host.addr, WRITE_BIT};
               data_q <= host.data;
               nack_f <= 1'b0;
               busy_r <= 1'b1;
               sda_lo <= 1'b0;
               scl_lo <= 1'b0;
            end
         end else if (tick) begin
            qp <= qp + 2'd1;
            unique case (state)
               START: begin
                  if (qp == QP1) sda_lo <= 1'b1;
                  if (qp == QP3) begin
                     state  <= ADDR;
                     scl_lo <= 1'b1;
                     sda_lo <= ~shreg[7];
                  end
               end
               ADDR, DATA: begin
                  if (qp == QP1) scl_lo <= 1'b0;
                  if (qp == QP3) begin
                     scl_lo <= 1'b1;
                     if (bitc == 3'd7) begin
                        state  <= (state == ADDR) ? ACK1 : ACK2;
                        sda_lo <= 1'b0;
                        bitc   <= '0;
                     end else begin
                        bitc   <= bitc + 3'd1;
                        shreg  <= {shreg[6:0], 1'b0};
                        sda_lo <= ~shreg[6];
                     end
                  end
               end
               ACK1, ACK2: begin
                  if (qp == QP1) scl_lo <= 1'b0;
                  // Released SDA reads high through the pull-up: NACK.
                  if (qp == QP2) nack_f <= nack_f | sda_in;
                  if (qp == QP3) begin
                     scl_lo <= 1'b1;
                     if (state == ACK1 && !nack_f) begin
                        state  <= DATA;
                        shreg  <= data_q;
                        sda_lo <= ~data_q[7];
                     end else begin
                        state  <= STOP;
                        sda_lo <= 1'b1;
                     end
                  end
               end
               STOP: begin
                  if (qp == QP0) scl_lo <= 1'b0;
                  if (qp == QP1) sda_lo <= 1'b0;
                  if (qp == QP3) begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     nack_r <= nack_f;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign sda = sda_lo ? 1'b0 : 1'bz;
   assign scl = scl_lo ? 1'b0 : 1'bz;

   assign host.busy = busy_r;
   assign host.done = done_r;
   assign host.nack = nack_r;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: scoreboard bench for i2c_master_ctrl (CLK_DIV=4 and 1).
// Bus-level slave model, START/STOP counter and done/latency/byte scoreboard.
module tb_i2c_master_ctrl;
   import i2c_pkg::*;

   typedef struct packed {
      logic        nack;
      logic [1:0]  nb;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   wire  sda0, scl0, sda1, scl1;

   pullup (sda0);
   pullup (scl0);
   pullup (sda1);
   pullup (scl1);

   i2c_master_ctrl_if if0 ();
   i2c_master_ctrl_if if1 ();

   i2c_master_ctrl #(.CLK_DIV(4)) u_dut0 (
      .clk  (clk),
      .rst  (rst),
      .host (if0),
      .sda  (sda0),
      .scl  (scl0)
   );

   i2c_master_ctrl #(.CLK_DIV(1)) u_dut1 (
      .clk  (clk),
      .rst  (rst),
      .host (if1),
      .sda  (sda1),
      .scl  (scl1)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int stray = 0;
   logic mon_en = 1'b0;
   logic [1:0] p_sda, p_scl, p_busy, in_xfer, slv_lo, nack_data;
   int bcnt [2];
   int bidx [2];
   int starts [2];
   int stops [2];
   int done_cnt [2];
   int busy_t [2];
   logic [7:0] sh [2];
   logic [7:0] slv_data [2];
   logic [7:0] seen0 [$];
   logic [7:0] seen1 [$];
   exp_t exp0 [$];
   exp_t exp1 [$];

   assign sda0 = slv_lo[0] ? 1'b0 : 1'bz;
   assign sda1 = slv_lo[1] ? 1'b0 : 1'bz;

   // Slave model, bus monitor and scoreboard, sampled on the falling edge.
   initial begin
      exp_t e;
      logic [1:0] cs, cl, cb, cd, cn;
      logic ack;
      logic [7:0] s0, s1;
      int n, lat;
      forever begin
         @(negedge clk);
         cyc++;
         cs = {sda1, sda0};
         cl = {scl1, scl0};
         cb = {if1.busy, if0.busy};
         cd = {if1.done, if0.done};
         cn = {if1.nack, if0.nack};
         for (int b = 0; b < 2; b++) begin
            if (mon_en) begin
               if (p_scl[b] && cl[b] && p_sda[b] && !cs[b]) begin
                  starts[b]++;
                  in_xfer[b] = 1'b1;
                  bcnt[b] = 0;
                  bidx[b] = 0;
                  slv_lo[b] = 1'b0;
               end else if (p_scl[b] && cl[b] && !p_sda[b] && cs[b]) begin
                  stops[b]++;
                  in_xfer[b] = 1'b0;
                  slv_lo[b] = 1'b0;
               end else if (in_xfer[b]) begin
                  if (!p_scl[b] && cl[b]) begin
                     if (bcnt[b] < 8) sh[b] = {sh[b][6:0], cs[b]};
                     bcnt[b]++;
                  end else if (p_scl[b] && !cl[b]) begin
                     if (bcnt[b] == 8) begin
                        if (b == 0) seen0.push_back(sh[b]);
                        else seen1.push_back(sh[b]);
                        if (bidx[b] == 0)
                           ack = (sh[b] == {DEF_SLAVE_ADDR, WRITE_BIT});
                        else
                           ack = !nack_data[b];
                        if (ack && bidx[b] == 1) slv_data[b] = sh[b];
                        slv_lo[b] = ack;
                     end else if (bcnt[b] == 9) begin
                        slv_lo[b] = 1'b0;
                        bcnt[b] = 0;
                        bidx[b]++;
                     end
                  end
               end
               if (cb[b] && !p_busy[b]) busy_t[b] = cyc;
               if (cn[b] && !cd[b]) stray++;
               if (cd[b]) begin
                  done_cnt[b]++;
                  n = (b == 0) ? seen0.size() : seen1.size();
                  s0 = 8'h00;
                  s1 = 8'h00;
                  if (n > 0) s0 = (b == 0) ? seen0[0] : seen1[0];
                  if (n > 1) s1 = (b == 0) ? seen0[1] : seen1[1];
                  tests++;
                  if (((b == 0) ? exp0.size() : exp1.size()) == 0) begin
                     fails++;
                     $display("FAIL unexpected_done dut%0d: got done, required none", b);
                  end else begin
                     if (b == 0) e = exp0.pop_front();
                     else e = exp1.pop_front();
                     if (cn[b] !== e.nack) begin
                        fails++;
                        $display("FAIL nack dut%0d: got %b required %b", b, cn[b], e.nack);
                     end
                     tests++;
                     lat = cyc - busy_t[b];
                     if (lat !== int'(e.lat)) begin
                        fails++;
                        $display("FAIL latency dut%0d: got %0d required %0d", b, lat, e.lat);
                     end
                     tests++;
                     if (n !== int'(e.nb) || (n > 0 && s0 !== e.b0) || (n > 1 && s1 !== e.b1)) begin
                        fails++;
                        $display("FAIL bus_bytes dut%0d: got n=%0d %h %h required n=%0d %h %h",
                                 b, n, s0, s1, e.nb, e.b0, e.b1);
                     end
                  end
                  if (b == 0) seen0.delete();
                  else seen1.delete();
               end
            end
         end
         p_sda = cs;
         p_scl = cl;
         p_busy = cb;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input int b, input logic [6:0] a, input logic [7:0] d,
                       input bit push, input logic en_nack, input int nb, input int lat);
      exp_t e;
      e.nack = en_nack;
      e.nb   = 2'(nb);
      e.b0   = {a, WRITE_BIT};
      e.b1   = d;
      e.lat  = 16'(lat);
      if (b == 0) begin
         if (push) exp0.push_back(e);
         if0.req = 1'b1; if0.addr = a; if0.data = d;
         step();
         if0.req = 1'b0;
      end else begin
         if (push) exp1.push_back(e);
         if1.req = 1'b1; if1.addr = a; if1.data = d;
         step();
         if1.req = 1'b0;
      end
   endtask

   task automatic wait_done(input int b, input int budget);
      int d0 = done_cnt[b];
      int n = 0;
      while (done_cnt[b] == d0 && n < budget) begin
         step();
         n++;
      end
      tests++;
      if (done_cnt[b] == d0) begin
         fails++;
         $display("FAIL done_timeout dut%0d: no done in %0d cycles, required done", b, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      tests++;
      if ({if0.busy, if0.done, if0.nack} !== 3'b000) begin
         fails++;
         $display("FAIL reset_status0: got %b required 000", {if0.busy, if0.done, if0.nack});
      end
      tests++;
      if ({if1.busy, if1.done, if1.nack} !== 3'b000) begin
         fails++;
         $display("FAIL reset_status1: got %b required 000", {if1.busy, if1.done, if1.nack});
      end
      tests++;
      if ({sda0, scl0, sda1, scl1} !== 4'b1111) begin
         fails++;
         $display("FAIL reset_bus: got %b required 1111", {sda0, scl0, sda1, scl1});
      end
      rst = 1'b0;
      step();
      mon_en = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_ack_write();
      int st = stops[0];
      send(0, DEF_SLAVE_ADDR, 8'hA5, 1'b1, 1'b0, 2, 320);
      wait_done(0, 1000);
      step();
      tests++;
      if (slv_data[0] !== 8'hA5) begin
         fails++;
         $display("FAIL slave_capture: got %h required a5", slv_data[0]);
      end
      tests++;
      if (stops[0] !== st + 1) begin
         fails++;
         $display("FAIL ack_stop: got %0d stops required %0d", stops[0] - st, 1);
      end
   endtask

   task automatic test_addr_nack();
      send(0, 7'b0000001, 8'h77, 1'b1, 1'b1, 1, 176);
      wait_done(0, 1000);
      repeat (4) step();
   endtask

   task automatic test_data_nack();
      int st = stops[0];
      nack_data[0] = 1'b1;
      send(0, DEF_SLAVE_ADDR, 8'h96, 1'b1, 1'b1, 2, 320);
      wait_done(0, 1000);
      step();
      nack_data[0] = 1'b0;
      tests++;
      if (stops[0] !== st + 1) begin
         fails++;
         $display("FAIL data_nack_stop: got %0d stops required 1", stops[0] - st);
      end
   endtask

   task automatic test_req_while_busy();
      int d0 = done_cnt[0];
      send(0, DEF_SLAVE_ADDR, 8'hA5, 1'b1, 1'b0, 2, 320);
      repeat (100) step();
      if0.req = 1'b1; if0.addr = DEF_SLAVE_ADDR; if0.data = 8'h3C;
      step();
      if0.req = 1'b0;
      wait_done(0, 1000);
      repeat (400) step();
      tests++;
      if (done_cnt[0] !== d0 + 1 || if0.busy !== 1'b0) begin
         fails++;
         $display("FAIL busy_req_ignored: got %0d done busy=%b required 1 done busy=0",
                  done_cnt[0] - d0, if0.busy);
      end
   endtask

   task automatic test_reset_mid_data();
      int n = 0;
      int d0;
      send(0, DEF_SLAVE_ADDR, 8'hA5, 1'b0, 1'b0, 2, 320);
      while (!(bidx[0] == 1 && bcnt[0] == 3 && scl0 == 1'b0) && n < 2000) begin
         step();
         n++;
      end
      tests++;
      if (n >= 2000) begin
         fails++;
         $display("FAIL reach_data_bit4: got timeout required 4th data bit");
      end
      d0 = done_cnt[0];
      rst = 1'b1;
      step();
      tests++;
      if ({if0.busy, if0.done, sda0, scl0} !== 4'b0011) begin
         fails++;
         $display("FAIL mid_reset: got busy,done,sda,scl=%b required 0011",
                  {if0.busy, if0.done, sda0, scl0});
      end
      rst = 1'b0;
      repeat (20) step();
      tests++;
      if (done_cnt[0] !== d0) begin
         fails++;
         $display("FAIL mid_reset_done: got %0d done required 0", done_cnt[0] - d0);
      end
      seen0.delete();
      send(0, DEF_SLAVE_ADDR, 8'h5A, 1'b1, 1'b0, 2, 320);
      wait_done(0, 1000);
      step();
      tests++;
      if (slv_data[0] !== 8'h5A) begin
         fails++;
         $display("FAIL post_reset_capture: got %h required 5a", slv_data[0]);
      end
   endtask

   task automatic test_back_to_back();
      send(1, DEF_SLAVE_ADDR, 8'hC3, 1'b1, 1'b0, 2, 80);
      wait_done(1, 500);
      send(1, DEF_SLAVE_ADDR, 8'h3A, 1'b1, 1'b0, 2, 80);
      tests++;
      if (if1.busy !== 1'b1) begin
         fails++;
         $display("FAIL b2b_accept: got busy=%b required 1", if1.busy);
      end
      wait_done(1, 500);
      repeat (4) step();
      tests++;
      if (slv_data[1] !== 8'h3A) begin
         fails++;
         $display("FAIL b2b_capture: got %h required 3a", slv_data[1]);
      end
   endtask

   task automatic test_protocol();
      tests++;
      if (starts[0] !== 6 || stops[0] !== 5) begin
         fails++;
         $display("FAIL bus0_start_stop: got %0d/%0d required 6/5", starts[0], stops[0]);
      end
      tests++;
      if (starts[1] !== 2 || stops[1] !== 2) begin
         fails++;
         $display("FAIL bus1_start_stop: got %0d/%0d required 2/2", starts[1], stops[1]);
      end
      tests++;
      if (stray !== 0) begin
         fails++;
         $display("FAIL stray_nack: got %0d cycles required 0", stray);
      end
      tests++;
      if (exp0.size() + exp1.size() + seen0.size() + seen1.size() !== 0) begin
         fails++;
         $display("FAIL leftovers: got exp %0d/%0d bytes %0d/%0d required 0",
                  exp0.size(), exp1.size(), seen0.size(), seen1.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      if0.req = 1'b0; if0.addr = '0; if0.data = '0;
      if1.req = 1'b0; if1.addr = '0; if1.data = '0;
      p_sda = 2'b11; p_scl = 2'b11; p_busy = 2'b00;
      in_xfer = 2'b00; slv_lo = 2'b00; nack_data = 2'b00;
      for (int i = 0; i < 2; i++) begin
         bcnt[i] = 0; bidx[i] = 0; starts[i] = 0; stops[i] = 0;
         done_cnt[i] = 0; busy_t[i] = 0; sh[i] = '0; slv_data[i] = '0;
      end
      test_reset();
      test_ack_write();
      test_addr_nack();
      test_data_nack();
      test_req_while_busy();
      test_reset_mid_data();
      test_back_to_back();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

endmodule
